key_event: RTL and testbench

//   Converts one debounced key level into single-cycle command pulses for the clock-setting logic.

---
 rtl/key_event_pkg.sv | 10 +
 rtl/key_event.sv | 66 ++++++
 tb/tb_key_event.sv | 114 +++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: state encoding and helpers shared by key_event and the time-set FSM.
package key_event_pkg;
  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_PRESS = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;
  function automatic int maxOf(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/key_event.sv
// key_event: turns a debounced key level into short/long/repeat command pulses.
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_db,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);
  localparam int CW = $clog2(maxOf(LONG_CYC, REPEAT_CYC));
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
  logic [1:0] state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic shortNext, longNext, repeatNext, heldNext;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_ARM;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  // A release always takes priority over a threshold hit on the same edge.
  always_comb begin
    stateNext = state;
    cntNext   = '0;
    case (state)
      ST_ARM:   stateNext = key_db ? ST_IDLE : ST_ARM;
      ST_IDLE:  stateNext = key_db ? ST_IDLE : ST_PRESS;
      ST_PRESS: begin
        stateNext = key_db ? ST_IDLE : (cnt == LONG_LAST ? ST_HOLD : ST_PRESS);
        cntNext   = (key_db || cnt == LONG_LAST) ? '0 : cnt + 1'b1;
      end
      default: begin
        stateNext = key_db ? ST_IDLE : ST_HOLD;
        cntNext   = (key_db || !REPEAT_EN) ? (key_db ? '0 : cnt) : (cnt == REP_LAST ? '0 : cnt + 1'b1);
      end
    endcase
  end
  always_comb begin
    shortNext  = state == ST_PRESS && key_db;
    longNext   = state == ST_PRESS && !key_db && cnt == LONG_LAST;
    repeatNext = REPEAT_EN && state == ST_HOLD && !key_db && cnt == REP_LAST;
    heldNext   = stateNext == ST_PRESS || stateNext == ST_HOLD;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      short_pulse  <= shortNext;
      long_pulse   <= longNext;
      repeat_pulse <= repeatNext;
      held         <= heldNext;
    end
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed checks of key_event with and without auto-repeat.
module tb_key_event;
  logic clk = 1'b0, rst = 1'b1, key_db = 1'b1;
  logic shortP, longP, repP, held, short0, long0, rep0, held0;
  int tests = 0, fails = 0, multi = 0;
  int e, nS, nL, nR, nH, lastS, lastL, nL0, nR0, nH0, lastL0;
  int rep[4];
  always #5 clk = ~clk;
  key_event #(.LONG_CYC(20), .REPEAT_CYC(5), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .key_db(key_db),
    .short_pulse(shortP), .long_pulse(longP), .repeat_pulse(repP), .held(held));
  key_event #(.LONG_CYC(20), .REPEAT_CYC(5), .REPEAT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .key_db(key_db),
    .short_pulse(short0), .long_pulse(long0), .repeat_pulse(rep0), .held(held0));
  task automatic chk(input string tag, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask
  task automatic clr();
    e = 0; nS = 0; nL = 0; nR = 0; nH = 0; lastS = -1; lastL = -1;
    nL0 = 0; nR0 = 0; nH0 = 0; lastL0 = -1;
    rep = '{default: -1};
  endtask
  // Edge index e counts edges since clr(); outputs are sampled 1 time unit after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (shortP) begin nS++; lastS = e; end
    if (longP) begin nL++; lastL = e; end
    if (repP) begin if (nR < 4) rep[nR] = e; nR++; end
    if (long0) begin nL0++; lastL0 = e; end
    if (rep0) nR0++;
    nH += int'(held);
    nH0 += int'(held0);
    if (int'(shortP) + int'(longP) + int'(repP) > 1 || int'(short0) + int'(long0) + int'(rep0) > 1) multi++;
    e++;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  initial begin
    #12;
    chk("rst_held", int'(held), 0);
    chk("rst_pulses", int'(shortP | longP | repP), 0);
    @(negedge clk) rst = 1'b0;
    ticks(2);
    clr(); key_db = 1'b0; ticks(5);
    chk("t1_held_cycles", nH, 5);
    key_db = 1'b1; tick();
    chk("t1_short_now", int'(shortP), 1);
    chk("t1_held_off", int'(held), 0);
    tick();
    chk("t1_short_1cyc", int'(shortP), 0);
    chk("t1_short_cnt", nS, 1);
    chk("t1_no_long_rep", nL + nR, 0);
    clr(); key_db = 1'b0; ticks(36);
    key_db = 1'b1; ticks(2);
    chk("t2_long_cnt", nL, 1);
    chk("t2_long_edge", lastL, 20);
    chk("t2_rep_cnt", nR, 3);
    chk("t2_rep0_edge", rep[0], 25);
    chk("t2_rep1_edge", rep[1], 30);
    chk("t2_rep2_edge", rep[2], 35);
    chk("t2_no_short", nS, 0);
    chk("t2_held_off", int'(held), 0);
    clr(); key_db = 1'b0; ticks(20);
    key_db = 1'b1; tick();
    chk("t3_short_now", int'(shortP), 1);
    chk("t3_short_edge", lastS, 20);
    chk("t3_no_long", nL, 0);
    key_db = 1'b0; tick();
    chk("t3_b2b_held", int'(held), 1);
    key_db = 1'b1; tick();
    chk("t3_b2b_short_cnt", nS, 2);
    tick();
    rst = 1'b1; key_db = 1'b0; #2; rst = 1'b0;
    clr(); ticks(30);
    chk("t4_quiet_hold", nS + nL + nR + nH, 0);
    key_db = 1'b1; tick();
    clr(); key_db = 1'b0; ticks(3);
    key_db = 1'b1; tick();
    chk("t4_short_cnt", nS, 1);
    chk("t4_short_edge", lastS, 3);
    chk("t4_no_long_rep", nL + nR, 0);
    tick();
    clr(); key_db = 1'b0; ticks(23);
    chk("t5_held_pre", int'(held), 1);
    chk("t5_long_pre", nL, 1);
    rst = 1'b1; #1;
    chk("t5_async_held", int'(held), 0);
    chk("t5_async_pulses", int'(shortP | longP | repP | held0), 0);
    #2; rst = 1'b0;
    clr(); ticks(10);
    key_db = 1'b1; tick();
    chk("t5_quiet", nS + nL + nR + nH, 0);
    key_db = 1'b0; ticks(2);
    key_db = 1'b1; tick();
    chk("t5_short_after", nS, 1);
    tick();
    clr(); key_db = 1'b0; ticks(60);
    chk("t6_long_cnt", nL0, 1);
    chk("t6_long_edge", lastL0, 20);
    chk("t6_no_rep", nR0, 0);
    chk("t6_held_cycles", nH0, 60);
    key_db = 1'b1; tick();
    chk("t6_held_off", int'(held0), 0);
    chk("one_pulse_max", multi, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
